seg_disp_sched: RTL and testbench

- Display scheduler in front of the 5-digit seven-segment scanner.
- Arbitrates display ownership between three requesters:
  - frequency-A edit events
  - frequency-B edit events
  - a status-message handshake
- Drives the scanner's num1/num2/num3 inputs, holding each page for a programmed time, then returns to the default page (freq A, freq B, wr_done).

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_ms_timer.sv | 50 +++++
 rtl/seg_disp_sched.sv | 168 ++++++++++++++++
 tb/tb_seg_disp_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display scheduler.
//   page_t          : scheduler state, doubling as the page code on the page port
//   PAGE_A_IND/_B   : fifth-digit indicator shown while a frequency page is held
//   CLK_PER_MS_DEF  : default sys_clk cycles per millisecond
//   MS_W            : width of millisecond load values / countdown
package seg_pkg;

  typedef enum logic [1:0] {
    NORM   = 2'd0,
    PAGE_A = 2'd1,
    PAGE_B = 2'd2,
    MSG    = 2'd3
  } page_t;

  localparam logic [3:0]  PAGE_A_IND     = 4'd1;
  localparam logic [3:0]  PAGE_B_IND     = 4'd2;
  localparam int unsigned CLK_PER_MS_DEF = 50_000;
  localparam int unsigned MS_W           = 16;

endpackage

// File: rtl/seg_ms_timer.sv
// Millisecond hold timer: a prescaler counting sys_clk cycles per ms plus a
// millisecond down-counter.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   restart            : clears the prescaler and loads load_ms
//   load_ms            : hold time in ms, sampled on restart
//   done               : one-cycle pulse in the last cycle of the hold, so the
//                        owner's state changes exactly load_ms*CLK_PER_MS
//                        cycles after the restart edge
module seg_ms_timer
  import seg_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            restart,
  input  logic [MS_W-1:0] load_ms,
  output logic            done
);

  localparam int unsigned    PW      = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(CLK_PER_MS - 1);

  logic [PW-1:0]   pre;
  logic [MS_W-1:0] ms;
  logic            wrap;

  assign wrap = (pre == PRE_MAX);
  // done is not gated by restart: restart is derived from done in the owner.
  assign done = wrap && (ms == MS_W'(1));

  // ms == 0 means idle; the counter parks there after the last decrement.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre <= '0;
      ms  <= '0;
    end else if (restart) begin
      pre <= '0;
      ms  <= load_ms;
    end else if (ms != '0) begin
      if (wrap) begin
        pre <= '0;
        ms  <= ms - 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Display scheduler in front of the 5-digit seven-segment scanner. Arbitrates
// between freq-A edits, freq-B edits and a status-message handshake, holding
// each page for a programmed time before returning to the default page.
//   sys_clk, sys_rst_n   : clock, asynchronous active-low reset
//   freq_a, freq_b       : live frequency selects
//   wr_done              : live write-done status
//   evt_a, evt_b         : one-cycle edit pulses
//   msg_req, msg_code    : message request (level) and its code
//   msg_ack              : one-cycle pulse on the edge that enters MSG
//   num1, num2, num3     : registered scanner inputs
//   page, busy           : current page code, busy = page != NORM
module seg_disp_sched
  import seg_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEF,
  parameter int unsigned HOLD_MS    = 2000,
  parameter int unsigned MSG_MS     = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] freq_a,
  input  logic [7:0] freq_b,
  input  logic [3:0] wr_done,
  input  logic       evt_a,
  input  logic       evt_b,
  input  logic       msg_req,
  input  logic [3:0] msg_code,
  output logic       msg_ack,
  output logic [7:0] num1,
  output logic [7:0] num2,
  output logic [3:0] num3,
  output logic [1:0] page,
  output logic       busy
);

  page_t           state, state_nx;
  logic            pend_a, pend_b, pend_a_nx, pend_b_nx;
  logic            restart, done, ack_nx;
  logic [3:0]      code_q, code_nx;
  logic [7:0]      num1_nx, num2_nx;
  logic [3:0]      num3_nx;
  logic [MS_W-1:0] load_ms;

  seg_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .restart   (restart),
    .load_ms   (load_ms),
    .done      (done)
  );

  always_comb begin
    state_nx  = state;
    pend_a_nx = pend_a;
    pend_b_nx = pend_b;
    restart   = 1'b0;

    unique case (state)
      NORM: begin
        if (msg_req)    state_nx = MSG;
        else if (evt_a) begin
          state_nx  = PAGE_A;
          pend_b_nx = evt_b;
        end
        else if (evt_b) state_nx = PAGE_B;
      end
      PAGE_A: begin
        if (msg_req) begin
          // Preempted page resumes after the message unless it was expiring.
          state_nx = MSG;
          if (!done || evt_a) pend_a_nx = 1'b1;
          if (evt_b)          pend_b_nx = 1'b1;
        end else if (evt_a) begin
          restart = 1'b1;
          if (evt_b) pend_b_nx = 1'b1;
        end else if (evt_b) begin
          state_nx = PAGE_B;
        end else if (done) begin
          if (pend_b) state_nx = PAGE_B;
          else        state_nx = NORM;
        end
      end
      PAGE_B: begin
        if (msg_req) begin
          state_nx = MSG;
          if (!done || evt_b) pend_b_nx = 1'b1;
          if (evt_a)          pend_a_nx = 1'b1;
        end else if (evt_a) begin
          state_nx = PAGE_A;
          if (evt_b) pend_b_nx = 1'b1;
        end else if (evt_b) begin
          restart = 1'b1;
        end else if (done) begin
          if (pend_a) state_nx = PAGE_A;
          else        state_nx = NORM;
        end
      end
      MSG: begin
        if (evt_a) pend_a_nx = 1'b1;
        if (evt_b) pend_b_nx = 1'b1;
        if (done) begin
          if (msg_req) begin
            restart = 1'b1;
          end
          else if (pend_a_nx) state_nx = PAGE_A;
          else if (pend_b_nx) state_nx = PAGE_B;
          else                state_nx = NORM;
        end
      end
    endcase

    if (state_nx != state && state_nx != NORM) restart = 1'b1;
    if (state_nx == PAGE_A) pend_a_nx = 1'b0;
    if (state_nx == PAGE_B) pend_b_nx = 1'b0;

    ack_nx  = (state_nx == MSG) && restart;
    code_nx = ack_nx ? msg_code : code_q;
    load_ms = (state_nx == MSG) ? MS_W'(MSG_MS) : MS_W'(HOLD_MS);

    // Outputs are registered from the next state so they change with page.
    num1_nx = freq_a;
    num2_nx = freq_b;
    num3_nx = wr_done;
    unique case (state_nx)
      NORM: ;
      PAGE_A: begin
        num2_nx = freq_a;
        num3_nx = PAGE_A_IND;
      end
      PAGE_B: begin
        num1_nx = freq_b;
        num3_nx = PAGE_B_IND;
      end
      MSG: begin
        num1_nx = '0;
        num2_nx = '0;
        num3_nx = code_nx;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= NORM;
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      code_q  <= '0;
      msg_ack <= 1'b0;
      busy    <= 1'b0;
      num1    <= '0;
      num2    <= '0;
      num3    <= '0;
    end else begin
      state   <= state_nx;
      pend_a  <= pend_a_nx;
      pend_b  <= pend_b_nx;
      code_q  <= code_nx;
      msg_ack <= ack_nx;
      busy    <= (state_nx != NORM);
      num1    <= num1_nx;
      num2    <= num2_nx;
      num3    <= num3_nx;
    end
  end

  assign page = state;

endmodule

// File: tb/tb_seg_disp_sched.sv
module tb_seg_disp_sched;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] freq_a, freq_b;
  logic [3:0] wr_done;
  logic       evt_a, evt_b, msg_req;
  logic [3:0] msg_code;
  logic       msg_ack;
  logic [7:0] num1, num2;
  logic [3:0] num3;
  logic [1:0] page;
  logic       busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       tag;
    logic [23:0] v;
  } exp_t;

  exp_t q[$];

  seg_disp_sched #(.CLK_PER_MS(10), .HOLD_MS(3), .MSG_MS(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .freq_a    (freq_a),
    .freq_b    (freq_b),
    .wr_done   (wr_done),
    .evt_a     (evt_a),
    .evt_b     (evt_b),
    .msg_req   (msg_req),
    .msg_code  (msg_code),
    .msg_ack   (msg_ack),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .page      (page),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // {page, busy, ack, num1, num2, num3}
  function automatic logic [23:0] pk(input logic [1:0] p, input logic [7:0] n1,
                                     input logic [7:0] n2, input logic [3:0] n3,
                                     input logic ack);
    return {p, (p != 2'd0), ack, n1, n2, n3};
  endfunction

  function automatic logic [23:0] observed();
    return {page, busy, msg_ack, num1, num2, num3};
  endfunction

  task automatic expect_n(input int n, input string tag, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock: pulses are dropped after the edge, then the next scoreboard entry is checked.
  task automatic step();
    exp_t e;
    logic [23:0] obs;
    @(posedge sys_clk);
    #1;
    evt_a = 1'b0;
    evt_b = 1'b0;
    if (q.size() > 0) begin
      e   = q.pop_front();
      obs = observed();
      total++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [23:0] NM, PA, PB;

  initial begin
    NM = pk(2'd0, 8'd37, 8'd52, 4'd5, 1'b0);
    PA = pk(2'd1, 8'd37, 8'd37, 4'd1, 1'b0);
    PB = pk(2'd2, 8'd52, 8'd52, 4'd2, 1'b0);

    sys_rst_n = 1'b0;
    freq_a    = 8'd37;
    freq_b    = 8'd52;
    wr_done   = 4'd5;
    evt_a     = 1'b0;
    evt_b     = 1'b0;
    msg_req   = 1'b0;
    msg_code  = 4'd0;

    // 1: reset values, then default page one cycle after release
    #12;
    chk("rst_hold", observed(), 24'h0);
    @(posedge sys_clk);
    #1;
    chk("rst_hold2", observed(), 24'h0);
    sys_rst_n = 1'b1;
    expect_n(3, "t1_norm", NM);
    run(3);

    // 2: single freq-A edit
    evt_a = 1'b1;
    expect_n(30, "t2_pa", PA);
    expect_n(3, "t2_norm", NM);
    run(33);

    // 3: repeated edit restarts the hold
    evt_a = 1'b1;
    expect_n(20, "t3_pa1", PA);
    run(20);
    evt_a = 1'b1;
    expect_n(30, "t3_pa2", PA);
    expect_n(3, "t3_norm", NM);
    run(33);

    // 4: message preempts page A, page A resumes with a full hold
    evt_a = 1'b1;
    expect_n(5, "t4_pa", PA);
    run(5);
    msg_req  = 1'b1;
    msg_code = 4'd7;
    expect_n(1, "t4_ack", pk(2'd3, 8'd0, 8'd0, 4'd7, 1'b1));
    run(1);
    msg_req  = 1'b0;
    msg_code = 4'hC;
    expect_n(19, "t4_msg", pk(2'd3, 8'd0, 8'd0, 4'd7, 1'b0));
    expect_n(30, "t4_pa_resume", PA);
    expect_n(3, "t4_norm", NM);
    run(52);

    // 5: simultaneous edits -> A then pending B
    evt_a = 1'b1;
    evt_b = 1'b1;
    expect_n(30, "t5_pa", PA);
    expect_n(30, "t5_pb", PB);
    expect_n(3, "t5_norm", NM);
    run(63);

    // 7: request held through expiry -> back-to-back message with new ack
    msg_req  = 1'b1;
    msg_code = 4'd3;
    expect_n(1, "t7_ack1", pk(2'd3, 8'd0, 8'd0, 4'd3, 1'b1));
    run(1);
    msg_code = 4'd5;
    expect_n(19, "t7_msg1", pk(2'd3, 8'd0, 8'd0, 4'd3, 1'b0));
    run(19);
    expect_n(1, "t7_ack2", pk(2'd3, 8'd0, 8'd0, 4'd5, 1'b1));
    run(1);
    msg_req = 1'b0;
    expect_n(19, "t7_msg2", pk(2'd3, 8'd0, 8'd0, 4'd5, 1'b0));
    expect_n(3, "t7_norm", NM);
    run(22);

    // 6: reset in the middle of a message with a pending page
    msg_req  = 1'b1;
    msg_code = 4'd9;
    expect_n(1, "t6_ack", pk(2'd3, 8'd0, 8'd0, 4'd9, 1'b1));
    run(1);
    msg_req = 1'b0;
    evt_a   = 1'b1;
    expect_n(4, "t6_msg", pk(2'd3, 8'd0, 8'd0, 4'd9, 1'b0));
    run(4);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_async_rst", observed(), 24'h0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    chk("t6_rst_hold", observed(), 24'h0);
    sys_rst_n = 1'b1;
    expect_n(40, "t6_norm_after", NM);
    run(40);

    chk("queue_drained", 24'(q.size()), 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
